instr_realigner: RTL

INSTR_REALIGNER -- requirements
Module: instr_realigner

---
 rtl/instr_realigner_pkg.sv | 17 +
 rtl/instr_realigner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instr_realigner_pkg.sv
// Shared definitions for the instruction realigner: residue state encoding and
// the RVC length test on a 16-bit parcel.
package instr_realigner_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RES_C = 2'd1,
    RES_U = 2'd2
  } realign_state_e;

  localparam logic [1:0] OPC_LEN32 = 2'b11;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != OPC_LEN32;
  endfunction

endpackage

// File: rtl/instr_realigner.sv
// Realigns 32-bit fetch words into whole RV32C instructions, carrying a single
// halfword residue across word boundaries, behind a one-deep output register.
module instr_realigner
  import instr_realigner_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic [31:0]       fetch_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic              instr_is_compressed_o
);

  realign_state_e    state_q, state_d;
  logic [15:0]       res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              instr_comp_q, instr_comp_d;

  logic              load;
  logic              accept;
  logic [15:0]       lo_half;
  logic [15:0]       hi_half;
  logic [ADDR_W-1:0] addr_plus2;
  logic              emit;
  logic [31:0]       emit_data;
  logic [ADDR_W-1:0] emit_addr;

  assign load       = !instr_valid_q || instr_ready_i;
  // A compressed residue is drained before the next word is taken.
  assign fetch_ready_o = load && !flush_i && !rst_i && (state_q != RES_C);
  assign accept     = fetch_valid_i && fetch_ready_o;
  assign lo_half    = fetch_data_i[15:0];
  assign hi_half    = fetch_data_i[31:16];
  assign addr_plus2 = fetch_addr_i + ADDR_W'(2);

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_addr_d = res_addr_q;
    emit       = 1'b0;
    emit_data  = '0;
    emit_addr  = '0;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (!fetch_addr_i[1]) begin
            emit      = 1'b1;
            emit_addr = fetch_addr_i;
            if (is_compressed(lo_half)) begin
              emit_data  = {16'h0, lo_half};
              res_data_d = hi_half;
              res_addr_d = addr_plus2;
              state_d    = is_compressed(hi_half) ? RES_C : RES_U;
            end else begin
              emit_data = fetch_data_i;
            end
          end else if (is_compressed(hi_half)) begin
            // Redirect into the upper half: the lower parcel is not on the path.
            emit      = 1'b1;
            emit_data = {16'h0, hi_half};
            emit_addr = fetch_addr_i;
          end else begin
            res_data_d = hi_half;
            res_addr_d = fetch_addr_i;
            state_d    = RES_U;
          end
        end
      end
      RES_C: begin
        if (load) begin
          emit      = 1'b1;
          emit_data = {16'h0, res_data_q};
          emit_addr = res_addr_q;
          state_d   = EMPTY;
        end
      end
      RES_U: begin
        if (accept) begin
          emit       = 1'b1;
          emit_data  = {lo_half, res_data_q};
          emit_addr  = res_addr_q;
          res_data_d = hi_half;
          res_addr_d = addr_plus2;
          state_d    = is_compressed(hi_half) ? RES_C : RES_U;
        end
      end
      default: state_d = EMPTY;
    endcase

    instr_d       = instr_q;
    instr_addr_d  = instr_addr_q;
    instr_comp_d  = instr_comp_q;
    instr_valid_d = instr_valid_q;
    if (load) begin
      instr_valid_d = emit;
      if (emit) begin
        instr_d      = emit_data;
        instr_addr_d = emit_addr;
        instr_comp_d = is_compressed(emit_data[15:0]);
      end
    end

    if (flush_i) begin
      state_d       = EMPTY;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= EMPTY;
      res_data_q    <= '0;
      res_addr_q    <= '0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      instr_comp_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      res_data_q    <= res_data_d;
      res_addr_q    <= res_addr_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_comp_q  <= instr_comp_d;
    end
  end

  assign instr_o               = instr_q;
  assign instr_addr_o          = instr_addr_q;
  assign instr_valid_o         = instr_valid_q;
  assign instr_is_compressed_o = instr_comp_q;

endmodule
